fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 8, data width per requester
- NREQ, 4, number of requesters (>=2)
- MAX_BURST, 4, max beats per grant (>=1)

REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, single clock; all state on rising edge
- i_reset_n, in, 1, asynchronous active-low reset
- i_req, in, NREQ, per-requester write request; bit k = requester k
- i_data, in, NREQ*WIDTH, requester k data in bits [k*WIDTH +: WIDTH]
- i_full, in, 1, FIFO full flag; no write while high
- o_gnt, out, NREQ, registered one-hot grant; all-zero when idle
- o_ack, out, NREQ, one-hot beat-accepted strobe to the granted requester
- o_wr_en, out, 1, FIFO write enable
- o_DATA, out, WIDTH, FIFO write data
- o_busy, out, 1, high while in GRANT state

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and GRANT; reset state IDLE.
REQ-004 In IDLE with i_req != 0, the block SHALL choose the first requester with i_req set, searching circularly from rr_ptr upward (wrap NREQ-1 -> 0).
- At the next edge, o_gnt SHALL become that one-hot and the state SHALL become GRANT.
REQ-005 In IDLE with i_req == 0, o_gnt SHALL stay 0 and the state SHALL stay IDLE.
REQ-006 A beat SHALL occur in a cycle where the state is GRANT, i_req[g]=1 for granted index g, and i_full=0.
REQ-007 o_wr_en and o_ack[g] SHALL be combinational and high exactly in beat cycles; all other o_ack bits SHALL be 0.
REQ-008 o_DATA SHALL equal i_data slice g while in GRANT and 0 in IDLE, as a combinational mux.
REQ-009 A beat counter of width $clog2(MAX_BURST+1) SHALL clear on entry to GRANT and increment by 1 per beat only; it SHALL never exceed MAX_BURST.
REQ-010 In GRANT, the grant SHALL be released at the next edge when either condition holds:
- a beat occurs and the counter reaches MAX_BURST, or
- i_req[g]=0 in that cycle.
REQ-011 On release:
- o_gnt SHALL go to 0 and the state to IDLE;
- rr_ptr SHALL become (g+1) mod NREQ;
- exactly one IDLE cycle SHALL separate consecutive grants.
REQ-012 While i_full=1 in GRANT, the grant SHALL be held, no beat SHALL occur, and the counter SHALL freeze; there is no stall timeout.
REQ-013 If i_req[g] drops in the same cycle as i_full=1, the release SHALL take priority, with no beat.
REQ-014 Requests from non-granted requesters SHALL be ignored until the next IDLE arbitration; no preemption.
REQ-015 o_busy SHALL equal (state == GRANT).
REQ-016 Request-to-first-beat latency from IDLE SHALL be 1 cycle, provided i_req stays high and i_full=0.

Reset
REQ-017 While i_reset_n=0, the following SHALL hold immediately (asynchronous):
- state=IDLE, o_gnt=0, counter=0, rr_ptr=0;
- o_ack=0, o_wr_en=0, o_DATA=0, o_busy=0.
REQ-018 Reset asserted mid-burst SHALL abort the burst with no further beats; after deassertion, arbitration SHALL restart from requester 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (MAX_BURST=4, NREQ=4, WIDTH=8 unless stated):
- Reset: hold i_reset_n=0 with i_req=4'hF -> o_gnt=0, o_wr_en=0, o_DATA=0, o_busy=0.
- Single requester: i_req=4'b0010 held for 6 beats, i_data[15:8]=8'hA0+n -> o_gnt=0010 one cycle after request; acks 1-4; 1 IDLE cycle; re-grant; acks 5-6; data A0..A5 in order on o_DATA.
- All requesting: i_req=4'hF held -> grant order 0,1,2,3,0, each exactly 4 consecutive o_wr_en cycles, one idle cycle between grants.
- Backpressure: i_full=1 for 3 cycles after beat 2 of requester 0 -> o_wr_en=0 for those 3 cycles; o_gnt held at 0001; beats 3-4 follow; release after beat 4.
- Early drop: requester 2 drops i_req after 2 beats while requesters 1 and 3 are requesting -> release next edge; next grant=4'b1000 (rr_ptr=3).
- Reset mid-burst: assert reset during grant 0100 with i_req=4'b1100 -> outputs 0 immediately; after release, grant=0100 (search from 0).

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST beats into a shared FIFO, honouring the FIFO full flag.
module fifo_wr_arb #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*WIDTH-1:0]   i_data,
  input  logic                    i_full,
  output logic [NREQ-1:0]         o_gnt,
  output logic [NREQ-1:0]         o_ack,
  output logic                    o_wr_en,
  output logic [WIDTH-1:0]        o_DATA,
  output logic                    o_busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int GW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]     idx_q, idx_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              busy_s;
  logic              req_g_s;
  logic              beat_s;
  logic              found_s;
  logic [GW-1:0]     pick_s;
  logic [WIDTH-1:0]  slice_s [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign slice_s[k] = i_data[k*WIDTH +: WIDTH];
  end

  assign busy_s  = (state_q == GRANT);
  assign req_g_s = |(i_req & gnt_q);
  assign beat_s  = busy_s & req_g_s & ~i_full;

  assign o_gnt   = gnt_q;
  assign o_busy  = busy_s;
  assign o_wr_en = beat_s;
  assign o_ack   = beat_s ? gnt_q : {NREQ{1'b0}};
  assign o_DATA  = busy_s ? slice_s[idx_q] : {WIDTH{1'b0}};

  // Circular first-set search starting at the round-robin pointer.
  always_comb begin
    logic [GW-1:0] k;
    found_s = 1'b0;
    pick_s  = ptr_q;
    k       = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      k = GW'((int'(ptr_q) + i) % NREQ);
      if (!found_s && i_req[k]) begin
        found_s = 1'b1;
        pick_s  = k;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic; a dropped request releases ahead of any full stall.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = GRANT;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
          idx_d   = pick_s;
          cnt_d   = {CW{1'b0}};
        end else begin
          gnt_d   = {NREQ{1'b0}};
        end
      end
      GRANT: begin
        if (beat_s) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (!req_g_s || (beat_s && (cnt_q + CW'(1) == CW'(MAX_BURST)))) begin
          state_d = IDLE;
          gnt_d   = {NREQ{1'b0}};
          ptr_d   = (idx_q == GW'(NREQ - 1)) ? {GW{1'b0}} : idx_q + GW'(1);
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {NREQ{1'b0}};
      end
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      gnt_q   <= {NREQ{1'b0}};
      idx_q   <= {GW{1'b0}};
      ptr_q   <= {GW{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: reset, single requester, full rotation,
// backpressure, early drop and reset mid-burst.
module tb_fifo_wr_arb;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic        i_full;
  logic [3:0]  o_gnt;
  logic [3:0]  o_ack;
  logic        o_wr_en;
  logic [7:0]  o_DATA;
  logic        o_busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  localparam logic [31:0] D = 32'hD3C2B1A0;

  fifo_wr_arb #(.WIDTH(8), .NREQ(4), .MAX_BURST(4)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (i_req),
    .i_data    (i_data),
    .i_full    (i_full),
    .o_gnt     (o_gnt),
    .o_ack     (o_ack),
    .o_wr_en   (o_wr_en),
    .o_DATA    (o_DATA),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic [3:0] gnt, input logic wr,
                          input logic busy, input logic [7:0] data);
    #1;
    chk({tag, " gnt"},   32'(o_gnt),   32'(gnt));
    chk({tag, " ack"},   32'(o_ack),   wr ? 32'(gnt) : 32'h0);
    chk({tag, " wr_en"}, 32'(o_wr_en), 32'(wr));
    chk({tag, " busy"},  32'(o_busy),  32'(busy));
    chk({tag, " data"},  32'(o_DATA),  32'(data));
  endtask

  function automatic logic [7:0] sl(input logic [31:0] d, input int g);
    return d[g*8 +: 8];
  endfunction

  initial begin
    logic [7:0] a;
    logic [3:0] g1h;
    int g;

    // Reset held with all requesting
    i_reset_n = 1'b0;
    i_req     = 4'hF;
    i_full    = 1'b0;
    i_data    = D;
    #2;
    expect_o("rst0", 4'h0, 1'b0, 1'b0, 8'h00);
    cyc();
    cyc();
    expect_o("rst1", 4'h0, 1'b0, 1'b0, 8'h00);
    i_reset_n = 1'b1;
    expect_o("rst_idle", 4'h0, 1'b0, 1'b0, 8'h00);
    cyc();

    // All requesting: order 0,1,2,3,0 with 4 beats each and one idle gap
    for (int k = 0; k < 5; k++) begin
      g   = k % 4;
      g1h = 4'b0001 << g;
      for (int b = 0; b < 4; b++) begin
        expect_o("all_beat", g1h, 1'b1, 1'b1, sl(D, g));
        cyc();
      end
      if (k == 4) i_req = 4'h0;
      expect_o("all_gap", 4'h0, 1'b0, 1'b0, 8'h00);
      cyc();
    end
    expect_o("all_idle", 4'h0, 1'b0, 1'b0, 8'h00);

    // Single requester 1 for 6 beats, data A0..A5
    i_data = 32'h0;
    i_req  = 4'b0010;
    expect_o("s_req", 4'h0, 1'b0, 1'b0, 8'h00);
    cyc();
    for (int n = 0; n < 6; n++) begin
      a = 8'hA0 + 8'(n);
      i_data[15:8] = a;
      expect_o("s_beat", 4'b0010, 1'b1, 1'b1, a);
      cyc();
      if (n == 3) begin
        expect_o("s_gap", 4'h0, 1'b0, 1'b0, 8'h00);
        cyc();
      end
    end
    i_req = 4'h0;
    expect_o("s_rel", 4'b0010, 1'b0, 1'b1, 8'hA5);
    cyc();
    i_data = D;
    i_req  = 4'b0001;
    expect_o("s_idle", 4'h0, 1'b0, 1'b0, 8'h00);
    cyc();

    // Backpressure: 3 full cycles after beat 2 of requester 0
    expect_o("bp_b1", 4'b0001, 1'b1, 1'b1, 8'hA0);
    cyc();
    expect_o("bp_b2", 4'b0001, 1'b1, 1'b1, 8'hA0);
    cyc();
    i_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      expect_o("bp_stall", 4'b0001, 1'b0, 1'b1, 8'hA0);
      cyc();
    end
    i_full = 1'b0;
    expect_o("bp_b3", 4'b0001, 1'b1, 1'b1, 8'hA0);
    cyc();
    expect_o("bp_b4", 4'b0001, 1'b1, 1'b1, 8'hA0);
    cyc();
    i_req = 4'h0;
    expect_o("bp_rel", 4'h0, 1'b0, 1'b0, 8'h00);
    cyc();

    // Early drop by requester 2 while 1 and 3 request
    i_req = 4'b0100;
    expect_o("ed_idle", 4'h0, 1'b0, 1'b0, 8'h00);
    cyc();
    expect_o("ed_b1", 4'b0100, 1'b1, 1'b1, 8'hC2);
    cyc();
    i_req = 4'b1110;
    expect_o("ed_b2", 4'b0100, 1'b1, 1'b1, 8'hC2);
    cyc();
    i_req = 4'b1010;
    expect_o("ed_drop", 4'b0100, 1'b0, 1'b1, 8'hC2);
    cyc();
    expect_o("ed_gap", 4'h0, 1'b0, 1'b0, 8'h00);
    cyc();
    expect_o("ed_next", 4'b1000, 1'b1, 1'b1, 8'hD3);
    cyc();
    // Drop coincident with full: release wins, no beat
    i_req  = 4'h0;
    i_full = 1'b1;
    expect_o("ed_dropfull", 4'b1000, 1'b0, 1'b1, 8'hD3);
    cyc();
    i_full = 1'b0;
    expect_o("ed_gap2", 4'h0, 1'b0, 1'b0, 8'h00);

    // Reset mid-burst of grant 0100
    i_req = 4'b1100;
    cyc();
    expect_o("rm_b1", 4'b0100, 1'b1, 1'b1, 8'hC2);
    cyc();
    expect_o("rm_b2", 4'b0100, 1'b1, 1'b1, 8'hC2);
    i_reset_n = 1'b0;
    expect_o("rm_rst", 4'h0, 1'b0, 1'b0, 8'h00);
    cyc();
    expect_o("rm_hold", 4'h0, 1'b0, 1'b0, 8'h00);
    i_reset_n = 1'b1;
    expect_o("rm_idle", 4'h0, 1'b0, 1'b0, 8'h00);
    cyc();
    expect_o("rm_regrant", 4'b0100, 1'b1, 1'b1, 8'hC2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
